// File: rtl/printer_arbiter.sv
// printer_arbiter: round-robin sharing of one UART string printer among
// NUM_REQ command-shell requesters, with one print job in flight at a time.

module printer_arbiter_slot #(
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [ID_W-1:0] str_id,
  input  logic            clear,
  output logic            pending,
  output logic [ID_W-1:0] id,
  output logic            drop
);
  // A request landing in this slot's completion cycle re-arms it instead of dropping.
  logic accept;
  assign accept = enable && (!pending || clear);
  assign drop   = enable && pending && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      id      <= '0;
    end else if (accept) begin
      pending <= 1'b1;
      id      <= str_id;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end
endmodule

module printer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_enable,
  input  logic [NUM_REQ*ID_W-1:0] req_str_id,
  output logic [NUM_REQ-1:0]      req_done,
  output logic [NUM_REQ-1:0]      req_busy,
  output logic                    req_overflow,
  output logic                    printer_enable,
  output logic [ID_W-1:0]         printer_str_id,
  input  logic                    printer_done,
  output logic [1:0]              arb_state
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

  state_t                       state, state_nxt;
  logic [NUM_REQ-1:0]           pending, clear, drop;
  logic [NUM_REQ-1:0][ID_W-1:0] id_reg;
  logic [IDX_W-1:0]             grant, last, winner;
  logic                         grant_load, done_hit;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign clear[i] = done_hit && (grant == IDX_W'(i));
    printer_arbiter_slot #(.ID_W(ID_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .enable  (req_enable[i]),
      .str_id  (req_str_id[i*ID_W +: ID_W]),
      .clear   (clear[i]),
      .pending (pending[i]),
      .id      (id_reg[i]),
      .drop    (drop[i])
    );
  end

  assign req_busy  = pending;
  assign arb_state = state;

  // Walk last+NUM_REQ down to last+1 so the nearest pending requester wins.
  always_comb begin
    int j;
    j      = 0;
    winner = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(last) + k) % NUM_REQ;
      if (pending[j[IDX_W-1:0]]) winner = j[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = (|pending) ? S_WAIT : S_IDLE;
      S_WAIT:  state_nxt = printer_done ? S_DONE : S_WAIT;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    grant_load = (state == S_IDLE) && (|pending);
    done_hit   = (state == S_WAIT) && printer_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant          <= '0;
      last           <= IDX_W'(NUM_REQ - 1);
      printer_enable <= 1'b0;
      printer_str_id <= '0;
      req_done       <= '0;
      req_overflow   <= 1'b0;
    end else begin
      printer_enable <= grant_load;
      req_done       <= done_hit ? (NUM_REQ'(1) << grant) : '0;
      req_overflow   <= req_overflow || (|drop);
      if (grant_load) begin
        grant          <= winner;
        last           <= winner;
        printer_str_id <= id_reg[winner];
      end
    end
  end
endmodule

// File: tb/tb_printer_arbiter.sv
// Directed bench for printer_arbiter: grant order, latency, overflow,
// completion-cycle re-request, spurious done and mid-job reset.

module tb_printer_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_REQ-1:0]      req_enable = '0;
  logic [NUM_REQ*ID_W-1:0] req_str_id = '0;
  logic [NUM_REQ-1:0]      req_done;
  logic [NUM_REQ-1:0]      req_busy;
  logic                    req_overflow;
  logic                    printer_enable;
  logic [ID_W-1:0]         printer_str_id;
  logic                    printer_done = 1'b0;
  logic [1:0]              arb_state;

  int n_chk  = 0;
  int n_fail = 0;

  printer_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_enable     (req_enable),
    .req_str_id     (req_str_id),
    .req_done       (req_done),
    .req_busy       (req_busy),
    .req_overflow   (req_overflow),
    .printer_enable (printer_enable),
    .printer_str_id (printer_str_id),
    .printer_done   (printer_done),
    .arb_state      (arb_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ids(input logic [1:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  // Called at a negedge; request is sampled on the next posedge.
  task automatic pulse_req(input logic [3:0] mask, input logic [7:0] id_vec);
    req_enable = mask;
    req_str_id = id_vec;
    @(negedge clk);
    req_enable = '0;
    req_str_id = '0;
  endtask

  task automatic wait_grant(input int req, input logic [1:0] id);
    int n;
    n = 0;
    while (!printer_enable && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant_seen", 32'(printer_enable), 1);
    chk("grant_id", 32'(printer_str_id), 32'(id));
    chk("grant_busy", 32'(req_busy[req]), 1);
  endtask

  task automatic finish(input int req, input int dly, input bit spur);
    repeat (dly) @(negedge clk);
    printer_done = 1'b1;
    @(negedge clk);
    printer_done = spur;
    chk("done_pulse", 32'(req_done), 32'(1 << req));
    chk("done_state", 32'(arb_state), 2);
    chk("pe_low", 32'(printer_enable), 0);
    @(negedge clk);
    printer_done = 1'b0;
    chk("done_clear", 32'(req_done), 0);
    chk("idle_state", 32'(arb_state), 0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_pe;
    @(negedge clk);
    chk("rst_state", 32'(arb_state), 0);
    chk("rst_pe", 32'(printer_enable), 0);
    chk("rst_busy", 32'(req_busy), 0);
    chk("rst_done", 32'(req_done), 0);
    chk("rst_ovf", 32'(req_overflow), 0);
    chk("rst_id", 32'(printer_str_id), 0);
    rst = 1'b0;

    // Single request, requester 2, ID 3
    pulse_req(4'b0100, ids(0, 3, 0, 0));
    chk("single_busy", 32'(req_busy), 32'b0100);
    chk("single_pe_early", 32'(printer_enable), 0);
    @(negedge clk);
    chk("single_pe_latency", 32'(printer_enable), 1);
    wait_grant(2, 3);
    @(negedge clk);
    chk("single_pe_one_cycle", 32'(printer_enable), 0);
    finish(2, 4, 0);
    chk("single_busy_clr", 32'(req_busy), 0);

    // Simultaneous requests 0,1,3 from reset pointer
    apply_reset();
    pulse_req(4'b1011, ids(3, 0, 1, 0));
    chk("sim_busy", 32'(req_busy), 32'b1011);
    wait_grant(0, 0);
    finish(0, 3, 0);
    wait_grant(1, 1);
    finish(1, 0, 0);
    wait_grant(3, 3);
    finish(3, 2, 0);
    chk("sim_busy_clr", 32'(req_busy), 0);
    pulse_req(4'b1001, ids(1, 0, 0, 2));
    wait_grant(0, 2);
    finish(0, 1, 0);
    wait_grant(3, 1);
    finish(3, 1, 0);

    // Duplicate request while in service
    pulse_req(4'b0010, ids(0, 0, 2, 0));
    wait_grant(1, 2);
    chk("dup_ovf_before", 32'(req_overflow), 0);
    pulse_req(4'b0010, ids(0, 0, 1, 0));
    chk("dup_ovf", 32'(req_overflow), 1);
    finish(1, 2, 0);
    chk("dup_busy_clr", 32'(req_busy), 0);
    saw_pe = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw_pe |= printer_enable;
    end
    chk("dup_single_print", 32'(saw_pe), 0);
    chk("dup_ovf_sticky", 32'(req_overflow), 1);

    // Re-request in the completion cycle
    apply_reset();
    pulse_req(4'b0001, ids(0, 0, 0, 1));
    wait_grant(0, 1);
    repeat (2) @(negedge clk);
    printer_done = 1'b1;
    req_enable   = 4'b0001;
    req_str_id   = ids(0, 0, 0, 2);
    @(negedge clk);
    printer_done = 1'b0;
    req_enable   = '0;
    req_str_id   = '0;
    chk("rereq_done", 32'(req_done), 1);
    chk("rereq_no_ovf", 32'(req_overflow), 0);
    chk("rereq_busy", 32'(req_busy), 1);
    wait_grant(0, 2);
    finish(0, 1, 0);
    chk("rereq_busy_clr", 32'(req_busy), 0);
    chk("rereq_ovf_final", 32'(req_overflow), 0);

    // Spurious printer_done in IDLE and in DONE
    printer_done = 1'b1;
    @(negedge clk);
    printer_done = 1'b0;
    chk("spur_idle_done", 32'(req_done), 0);
    chk("spur_idle_state", 32'(arb_state), 0);
    pulse_req(4'b0100, ids(0, 1, 0, 0));
    wait_grant(2, 1);
    finish(2, 2, 1);
    chk("spur_done_pe", 32'(printer_enable), 0);
    chk("spur_done_busy", 32'(req_busy), 0);

    // Reset between grant and done with two requests pending
    pulse_req(4'b0011, ids(0, 0, 2, 1));
    wait_grant(0, 1);
    rst = 1'b1;
    #1;
    chk("midrst_pe", 32'(printer_enable), 0);
    chk("midrst_state", 32'(arb_state), 0);
    chk("midrst_busy", 32'(req_busy), 0);
    chk("midrst_done", 32'(req_done), 0);
    chk("midrst_id", 32'(printer_str_id), 0);
    @(negedge clk);
    rst = 1'b0;
    pulse_req(4'b1000, ids(3, 0, 0, 0));
    @(negedge clk);
    chk("postrst_pe_latency", 32'(printer_enable), 1);
    wait_grant(3, 3);
    finish(3, 1, 0);
    chk("postrst_busy_clr", 32'(req_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
